// File: rtl/resp_router_pkg.sv
// Shared definitions for the response path: default sizing and the {source, data} entry
// shared with the upstream arbiter.
package resp_router_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic                  source;
    logic [DATA_W_DEF-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// In-order FIFO with a valid/ready handshake on both sides. Occupancy is held in its own
// counter rather than derived from the pointers.
module resp_fifo
  import resp_router_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = DATA_W_DEF + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [W-1:0]             enq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [W-1:0]             deq_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire;

  // Readiness depends only on registered occupancy; a full FIFO refuses even
  // when a dequeue happens in the same cycle.
  assign enq_ready = (count_q != FULL_C);
  assign deq_valid = (count_q != '0);
  assign deq_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: rtl/resp_router.sv
// Routes buffered responses to one of two requesters strictly in arrival order;
// a stalled head blocks everything behind it.
module resp_router
  import resp_router_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic                    io_in_bits_source,
  input  logic [DATA_W-1:0]       io_in_bits_data,
  output logic                    io_out_0_valid,
  input  logic                    io_out_0_ready,
  output logic [DATA_W-1:0]       io_out_0_bits_data,
  output logic                    io_out_1_valid,
  input  logic                    io_out_1_ready,
  output logic [DATA_W-1:0]       io_out_1_bits_data,
  output logic [$clog2(DEPTH):0]  io_count
);

  logic              head_valid;
  logic              head_ready;
  logic [DATA_W:0]   head_entry;
  logic              head_src;

  resp_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (io_in_valid),
    .enq_ready (io_in_ready),
    .enq_data  ({io_in_bits_source, io_in_bits_data}),
    .deq_valid (head_valid),
    .deq_ready (head_ready),
    .deq_data  (head_entry),
    .count     (io_count)
  );

  assign head_src = head_entry[DATA_W];

  assign io_out_0_valid     = head_valid & ~head_src;
  assign io_out_1_valid     = head_valid &  head_src;
  assign io_out_0_bits_data = head_entry[DATA_W-1:0];
  assign io_out_1_bits_data = head_entry[DATA_W-1:0];

  // Only the ready of the requester that owns the head can pop it.
  assign head_ready = head_src ? io_out_1_ready : io_out_0_ready;

endmodule

// File: tb/tb_resp_router.sv
// Directed bench for resp_router: a reference queue holds the expected entries and is
// checked against the outputs every cycle.
module tb_resp_router;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_in_valid;
  logic              io_in_ready;
  logic              io_in_bits_source;
  logic [DATA_W-1:0] io_in_bits_data;
  logic              io_out_0_valid;
  logic              io_out_0_ready;
  logic [DATA_W-1:0] io_out_0_bits_data;
  logic              io_out_1_valid;
  logic              io_out_1_ready;
  logic [DATA_W-1:0] io_out_1_bits_data;
  logic [CW-1:0]     io_count;

  typedef struct {
    logic              src;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   delivered = 0;

  always #5 clock = ~clock;

  resp_router #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits_source  (io_in_bits_source),
    .io_in_bits_data    (io_in_bits_data),
    .io_out_0_valid     (io_out_0_valid),
    .io_out_0_ready     (io_out_0_ready),
    .io_out_0_bits_data (io_out_0_bits_data),
    .io_out_1_valid     (io_out_1_valid),
    .io_out_1_ready     (io_out_1_ready),
    .io_out_1_bits_data (io_out_1_bits_data),
    .io_count           (io_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: check outputs against the
  // reference queue, then advance one rising edge and update the queue.
  task automatic step();
    logic enq, deq;
    chk("in_ready", 64'(io_in_ready), 64'(sb.size() < DEPTH));
    chk("count", 64'(io_count), 64'(sb.size()));
    if (sb.size() > 0) begin
      chk("out0_valid", 64'(io_out_0_valid), 64'(!sb[0].src));
      chk("out1_valid", 64'(io_out_1_valid), 64'(sb[0].src));
      chk("out0_data", 64'(io_out_0_bits_data), 64'(sb[0].data));
      chk("out1_data", 64'(io_out_1_bits_data), 64'(sb[0].data));
    end else begin
      chk("out0_valid_empty", 64'(io_out_0_valid), 64'(0));
      chk("out1_valid_empty", 64'(io_out_1_valid), 64'(0));
    end
    enq = io_in_valid && (sb.size() < DEPTH);
    deq = (sb.size() > 0) && (sb[0].src ? io_out_1_ready : io_out_0_ready);
    if ((io_out_0_valid && io_out_0_ready) || (io_out_1_valid && io_out_1_ready))
      delivered++;
    @(posedge clock);
    if (deq) void'(sb.pop_front());
    if (enq) sb.push_back('{io_in_bits_source, io_in_bits_data});
    @(negedge clock);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    int idx;
    int cyc;

    reset = 1'b0;
    io_in_valid = 1'b0;
    io_in_bits_source = 1'b0;
    io_in_bits_data = '0;
    io_out_0_ready = 1'b0;
    io_out_1_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(io_in_ready), 64'(1));
    chk("rst_out0_valid", 64'(io_out_0_valid), 64'(0));
    chk("rst_out1_valid", 64'(io_out_1_valid), 64'(0));
    chk("rst_count", 64'(io_count), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Single response to requester 1 with both readies up.
    io_in_valid = 1'b1;
    io_in_bits_source = 1'b1;
    io_in_bits_data = 32'hDEADBEEF;
    io_out_0_ready = 1'b1;
    io_out_1_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    chk("single_out1_valid", 64'(io_out_1_valid), 64'(1));
    chk("single_out1_data", 64'(io_out_1_bits_data), 64'hDEADBEEF);
    chk("single_out0_valid", 64'(io_out_0_valid), 64'(0));
    step();
    chk("single_count_after", 64'(io_count), 64'(0));

    // Fill with readies low; a fifth push must bounce.
    io_out_0_ready = 1'b0;
    io_out_1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      io_in_valid = 1'b1;
      io_in_bits_source = i[0];
      io_in_bits_data = 32'h10 + 32'(i);
      step();
    end
    io_in_bits_source = 1'b1;
    io_in_bits_data = 32'h99;
    chk("full_in_ready", 64'(io_in_ready), 64'(0));
    chk("full_count", 64'(io_count), 64'(4));
    step();
    chk("fifth_refused_count", 64'(io_count), 64'(4));

    // Full with a dequeue in the same cycle: still no enqueue.
    io_in_bits_data = 32'h77;
    io_out_0_ready = 1'b1;
    step();
    io_in_valid = 1'b0;
    io_out_0_ready = 1'b0;
    chk("full_deq_count", 64'(io_count), 64'(3));

    // Pop the src=1 head so a src=0 head sits in front of a src=1 entry.
    io_out_1_ready = 1'b1;
    step();
    io_out_1_ready = 1'b0;
    chk("hol_head_data", 64'(io_out_0_bits_data), 64'h12);
    held = io_out_0_bits_data;
    io_out_1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hol_stable_valid", 64'(io_out_0_valid), 64'(1));
      chk("hol_stable_data", 64'(io_out_0_bits_data), 64'(held));
      chk("hol_count", 64'(io_count), 64'(2));
    end
    io_out_0_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("drain_empty", 64'(io_count), 64'(0));

    // Ten alternating-source responses against random back-pressure.
    delivered = 0;
    idx = 0;
    cyc = 0;
    while ((idx < 10 || sb.size() > 0) && cyc < 300) begin
      io_in_valid = (idx < 10);
      io_in_bits_source = idx[0];
      io_in_bits_data = 32'h100 + 32'(idx);
      io_out_0_ready = 1'($urandom_range(0, 1));
      io_out_1_ready = 1'($urandom_range(0, 1));
      if (io_in_valid && sb.size() < DEPTH) idx++;
      step();
      cyc++;
    end
    io_in_valid = 1'b0;
    chk("rand_all_pushed", 64'(idx), 64'(10));
    chk("rand_delivered", 64'(delivered), 64'(10));
    chk("rand_count", 64'(io_count), 64'(0));

    // Reset mid-operation with three entries held.
    io_out_0_ready = 1'b0;
    io_out_1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1;
      io_in_bits_source = i[0];
      io_in_bits_data = 32'h200 + 32'(i);
      step();
    end
    io_in_valid = 1'b0;
    chk("pre_reset_count", 64'(io_count), 64'(3));
    #2;
    reset = 1'b0;
    #1;
    chk("async_in_ready", 64'(io_in_ready), 64'(1));
    chk("async_out0_valid", 64'(io_out_0_valid), 64'(0));
    chk("async_out1_valid", 64'(io_out_1_valid), 64'(0));
    chk("async_count", 64'(io_count), 64'(0));
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    io_out_0_ready = 1'b1;
    io_out_1_ready = 1'b1;
    step();
    step();
    chk("post_reset_count", 64'(io_count), 64'(0));
    chk("post_reset_in_ready", 64'(io_in_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
